// File: rtl/mod_differentiator_if.sv
// Stream-side bundle for mod_differentiator: upstream sample handshake,
// modulus, downstream result handshake and the sticky error flag.
interface mod_differentiator_if #(
    parameter int unsigned BITWIDTH = 32
);
    logic                iClr;
    logic                iValid;
    logic                oReady;
    logic [BITWIDTH-1:0] iData;
    logic [BITWIDTH-1:0] iQ;
    logic                oValid;
    logic                iReady;
    logic [BITWIDTH-1:0] oData;
    logic                oErr;

    // master drives samples and consumes results; slave is the differentiator
    modport master (
        output iClr, iValid, iData, iQ, iReady,
        input  oReady, oValid, oData, oErr
    );

    modport slave (
        input  iClr, iValid, iData, iQ, iReady,
        output oReady, oValid, oData, oErr
    );
endinterface

// File: rtl/mod_differentiator.sv
// Modular differentiator: inverts a mod-iQ running sum back into its increments,
// with a single-entry output stage and a sticky flag for out-of-range samples.
module mod_differentiator #(
    parameter int unsigned BITWIDTH = 32
) (
    input  logic                  iClk,
    input  logic                  iRst,
    mod_differentiator_if.slave   bus
);
    logic [BITWIDTH-1:0] prev;
    logic [BITWIDTH-1:0] dataR;
    logic                validR;
    logic                errR;

    logic                ready;
    logic                accept;
    logic                inRange;
    logic                drain;
    logic [BITWIDTH-1:0] diff;
    logic                unusedCarry;

    assign ready   = ~validR | bus.iReady;
    assign accept  = bus.iValid & ready & ~bus.iClr;
    assign inRange = bus.iData < bus.iQ;
    assign drain   = validR & bus.iReady;

    // Wrap term x + q - prev is formed one bit wider so q near 2^BITWIDTH cannot overflow.
    always_comb begin
        {unusedCarry, diff} = '0;
        if (bus.iData >= prev)
            {unusedCarry, diff} = {1'b0, bus.iData} - {1'b0, prev};
        else
            {unusedCarry, diff} = {1'b0, bus.iData} + {1'b0, bus.iQ} - {1'b0, prev};
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            prev   <= '0;
            dataR  <= '0;
            validR <= 1'b0;
            errR   <= 1'b0;
        end else if (bus.iClr) begin
            prev   <= '0;
            validR <= 1'b0;
            errR   <= 1'b0;
        end else begin
            if (accept && inRange) begin
                dataR  <= diff;
                validR <= 1'b1;
                prev   <= bus.iData;
            end else begin
                if (accept)
                    errR <= 1'b1;
                if (drain)
                    validR <= 1'b0;
            end
        end
    end

    assign bus.oReady = ready;
    assign bus.oValid = validR;
    assign bus.oData  = dataR;
    assign bus.oErr   = errR;
endmodule

// File: tb/tb_mod_differentiator.sv
// Directed and randomized round-trip checks of mod_differentiator at
// BITWIDTH = 8, iQ = 17.
module tb_mod_differentiator;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mod_differentiator_if #(.BITWIDTH(8)) bus();

    mod_differentiator #(.BITWIDTH(8)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        bus.iClr   = 1'b1;
        bus.iValid = 1'b0;
        step();
        bus.iClr   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iValid = 1'b1;
        bus.iData  = 8'd7;
        step();
        rst = 1'b0;
        bus.iValid = 1'b0;
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL reset_oValid got=%0b exp=0", bus.oValid); end
        checks++; if (bus.oData !== 8'd0) begin errors++; $display("FAIL reset_oData got=%0d exp=0", bus.oData); end
        checks++; if (bus.oErr !== 1'b0) begin errors++; $display("FAIL reset_oErr got=%0b exp=0", bus.oErr); end
        checks++; if (bus.oReady !== 1'b1) begin errors++; $display("FAIL reset_oReady got=%0b exp=1", bus.oReady); end
    endtask

    task automatic test_basic();
        logic [7:0] ins [5] = '{8'd5, 8'd12, 8'd3, 8'd3, 8'd16};
        logic [7:0] exps[5] = '{8'd5, 8'd7, 8'd8, 8'd0, 8'd13};
        bus.iReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.iValid = 1'b1;
            bus.iData  = ins[i];
            step();
            checks++; if (bus.oValid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got=%0b exp=1", i, bus.oValid); end
            checks++; if (bus.oData !== exps[i]) begin errors++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, bus.oData, exps[i]); end
        end
        bus.iValid = 1'b0;
        step();
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%0b exp=0", bus.oValid); end
    endtask

    task automatic test_wrap();
        logic [7:0] ins [4] = '{8'd16, 8'd0, 8'd9, 8'd16};
        logic [7:0] exps[4] = '{8'd16, 8'd1, 8'd9, 8'd7};
        do_clear();
        bus.iReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // after 16 -> 0, clear so the third sample is differenced against 0
            if (i == 2) do_clear();
            bus.iValid = 1'b1;
            bus.iData  = ins[i];
            step();
            bus.iValid = 1'b0;
            checks++; if (bus.oData !== exps[i]) begin errors++; $display("FAIL wrap_data[%0d] got=%0d exp=%0d", i, bus.oData, exps[i]); end
        end
        bus.iValid = 1'b1;
        bus.iData  = 8'd8;
        step();
        bus.iValid = 1'b0;
        checks++; if (bus.oData !== 8'd9) begin errors++; $display("FAIL wrap_9to8 got=%0d exp=9", bus.oData); end
        do_clear();
        bus.iValid = 1'b1;
        bus.iData  = 8'd9;
        step();
        bus.iData  = 8'd8;
        step();
        bus.iValid = 1'b0;
        checks++; if (bus.oData !== 8'd16) begin errors++; $display("FAIL wrap_prev9_in8 got=%0d exp=16", bus.oData); end
        step();
    endtask

    task automatic test_backpressure();
        do_clear();
        bus.iReady = 1'b1;
        bus.iValid = 1'b1;
        bus.iData  = 8'd4;
        step();
        bus.iReady = 1'b0;
        bus.iData  = 8'd10;
        #1;
        checks++; if (bus.oReady !== 1'b0) begin errors++; $display("FAIL bp_oReady_low got=%0b exp=0", bus.oReady); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.oValid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got=%0b exp=1", i, bus.oValid); end
            checks++; if (bus.oData !== 8'd4) begin errors++; $display("FAIL bp_hold_data[%0d] got=%0d exp=4", i, bus.oData); end
            checks++; if (bus.oReady !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d] got=%0b exp=0", i, bus.oReady); end
        end
        bus.iReady = 1'b1;
        #1;
        checks++; if (bus.oReady !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", bus.oReady); end
        step();
        bus.iValid = 1'b0;
        checks++; if (bus.oValid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got=%0b exp=1", bus.oValid); end
        checks++; if (bus.oData !== 8'd6) begin errors++; $display("FAIL bp_next_data got=%0d exp=6", bus.oData); end
        step();
    endtask

    task automatic test_error();
        do_clear();
        bus.iReady = 1'b1;
        bus.iValid = 1'b1;
        bus.iData  = 8'd4;
        step();
        bus.iData  = 8'd20;
        step();
        checks++; if (bus.oErr !== 1'b1) begin errors++; $display("FAIL err_flag got=%0b exp=1", bus.oErr); end
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL err_no_output got=%0b exp=0", bus.oValid); end
        bus.iData  = 8'd17;
        step();
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL err_eq_q_no_output got=%0b exp=0", bus.oValid); end
        bus.iData  = 8'd7;
        step();
        bus.iValid = 1'b0;
        checks++; if (bus.oData !== 8'd3) begin errors++; $display("FAIL err_prev_kept got=%0d exp=3", bus.oData); end
        checks++; if (bus.oErr !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0b exp=1", bus.oErr); end
        do_clear();
        checks++; if (bus.oErr !== 1'b0) begin errors++; $display("FAIL err_clear got=%0b exp=0", bus.oErr); end
    endtask

    task automatic test_clear_reset();
        do_clear();
        bus.iReady = 1'b1;
        bus.iValid = 1'b1;
        bus.iData  = 8'd5;
        step();
        bus.iReady = 1'b0;
        bus.iClr   = 1'b1;
        bus.iData  = 8'd9;
        step();
        bus.iClr   = 1'b0;
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL clr_discard got=%0b exp=0", bus.oValid); end
        bus.iReady = 1'b1;
        step();
        checks++; if (bus.oData !== 8'd9) begin errors++; $display("FAIL clr_restart got=%0d exp=9", bus.oData); end
        bus.iData  = 8'd3;
        step();
        checks++; if (bus.oData !== 8'd11) begin errors++; $display("FAIL pre_rst_data got=%0d exp=11", bus.oData); end
        rst = 1'b1;
        bus.iClr   = 1'b1;
        bus.iData  = 8'd12;
        step();
        rst = 1'b0;
        bus.iClr   = 1'b0;
        bus.iValid = 1'b0;
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", bus.oValid); end
        checks++; if (bus.oData !== 8'd0) begin errors++; $display("FAIL rst_data got=%0d exp=0", bus.oData); end
        bus.iValid = 1'b1;
        bus.iData  = 8'd6;
        step();
        bus.iValid = 1'b0;
        checks++; if (bus.oData !== 8'd6) begin errors++; $display("FAIL rst_restart got=%0d exp=6", bus.oData); end
        step();
    endtask

    task automatic test_roundtrip();
        localparam int N = 40;
        logic [7:0] incs[N];
        logic [7:0] sums[N];
        logic [7:0] acc;
        logic       mValid;
        logic       v;
        logic       r;
        logic       take;
        int         sent;
        int         delivered;
        acc = 8'd0;
        for (int i = 0; i < N; i++) begin
            incs[i] = 8'($urandom_range(0, 16));
            acc     = 8'((int'(acc) + int'(incs[i])) % 17);
            sums[i] = acc;
        end
        do_clear();
        mValid    = 1'b0;
        sent      = 0;
        delivered = 0;
        for (int cyc = 0; cyc < 2000 && delivered < N; cyc++) begin
            v = (sent < N) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 2) != 0);
            bus.iValid = v;
            bus.iData  = (sent < N) ? sums[sent] : 8'd0;
            bus.iReady = r;
            if (mValid && r) begin
                checks++; if (bus.oData !== incs[delivered]) begin errors++; $display("FAIL rt_data[%0d] got=%0d exp=%0d", delivered, bus.oData, incs[delivered]); end
                delivered++;
            end
            take = v && (!mValid || r);
            if (take) begin
                mValid = 1'b1;
                sent++;
            end else if (mValid && r) begin
                mValid = 1'b0;
            end
            step();
            checks++; if (bus.oValid !== mValid) begin errors++; $display("FAIL rt_valid[%0d] got=%0b exp=%0b", cyc, bus.oValid, mValid); end
        end
        bus.iValid = 1'b0;
        bus.iReady = 1'b1;
        checks++; if (delivered !== N) begin errors++; $display("FAIL rt_count got=%0d exp=%0d", delivered, N); end
        step();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.iClr   = 1'b0;
        bus.iValid = 1'b0;
        bus.iData  = 8'd0;
        bus.iQ     = 8'd17;
        bus.iReady = 1'b1;
        step();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_error();
        test_clear_reset();
        test_roundtrip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mod_differentiator.md
MOD_DIFFERENTIATOR -- requirements
Module: mod_differentiator

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, data and modulus width in bits.
REQ-002 SHALL have port iClk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port iRst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port iClr, input, 1, synchronous stream restart.
REQ-005 SHALL have port iValid, input, 1, upstream sample valid.
REQ-006 SHALL have port oReady, output, 1, block can accept a sample this cycle.
REQ-007 SHALL have port iData, input, BITWIDTH, running modular sum sample, nominally < iQ.
REQ-008 SHALL have port iQ, input, BITWIDTH, modulus; nonzero, held stable while a stream is active.
REQ-009 SHALL have port oValid, output, 1, oData holds an undelivered result.
REQ-010 SHALL have port iReady, input, 1, downstream accepts oData.
REQ-011 SHALL have port oData, output, BITWIDTH, modular difference result.
REQ-012 SHALL have port oErr, output, 1, sticky out-of-range input flag.

Function
REQ-013 SHALL hold internal register prev (BITWIDTH), the last accepted sample, initially 0.
REQ-014 SHALL drive oReady = ~oValid | iReady (single-entry output stage, combinational pass-through of backpressure).
REQ-015 SHALL accept a sample when iValid & oReady & ~iClr; no other condition consumes iData.
REQ-016 SHALL, on acceptance of x with x < iQ, compute on BITWIDTH+1 bits: d = x - prev if x >= prev, else x + iQ - prev; d is always in [0, iQ).
REQ-017 SHALL, on that same edge, load oData <= d[BITWIDTH-1:0], set oValid <= 1, and set prev <= x; latency is exactly 1 cycle from acceptance to oValid.
REQ-018 SHALL, on acceptance of x with x >= iQ, drop the sample: prev unchanged, no output produced, oErr <= 1.
REQ-019 SHALL clear oValid on an edge where oValid & iReady and no new sample is accepted; on simultaneous drain and accept, oValid stays 1 with the new result (back-to-back throughput 1 sample/cycle).
REQ-020 SHALL hold oData and oValid unchanged while oValid & ~iReady; oReady is then 0 and iData is ignored.
REQ-021 SHALL, when iClr = 1, on that edge set prev <= 0, oValid <= 0, and oErr <= 0, discard any pending result, and accept no sample; iClr overrides iValid and iReady.
REQ-022 SHALL make the block the exact inverse of a modular accumulator that starts from 0: feeding its output stream s[n] yields the original increments a[n] mod iQ.
REQ-023 SHALL keep oData unchanged whenever oValid = 0, except as written by REQ-017 or reset.
REQ-024 SHALL compute wrap-around without overflow for any iQ up to 2^BITWIDTH - 1 (x + iQ carried in the BITWIDTH+1 intermediate).

Reset
REQ-025 SHALL, when iRst = 1 at a rising edge, set prev = 0, oData = 0, oValid = 0, oErr = 0; oReady = 1 in the following cycle.
REQ-026 SHALL give iRst priority over iClr and over any handshake; a reset mid-stream discards pending output and history.
REQ-027 SHALL hold no state outside the registers listed; the first sample after reset or clear is differenced against 0.

Verification (BITWIDTH = 8, iQ = 17, iReady = 1 unless stated)
REQ-028 SHALL check the basic stream: inputs 5, 12, 3, 3, 16 -> outputs 5, 7, 8, 0, 13, each 1 cycle after acceptance.
REQ-029 SHALL check the wrap boundary: prev = 16, input 0 -> oData 1; prev = 0, input 16 -> 16; prev = 9, input 8 -> 16.
REQ-030 SHALL check backpressure: iReady = 0 for 3 cycles with iValid held at 10 after a 4 -> oValid/oData = 4 held, oReady = 0, prev stays 4; release -> next output 6.
REQ-031 SHALL check the error path: input 20 -> oErr = 1, no oValid, prev unchanged; next input 7 after prev = 4 -> 3; iClr -> oErr = 0.
REQ-032 SHALL check clear and reset: iClr asserted together with iValid (data 9) and a pending result -> oValid = 0, sample not taken, next input 9 -> 9; iRst mid-stream -> all outputs 0, then input 6 -> 6.
REQ-033 SHALL check the round trip: a random increment stream fed through a reference mod-17 accumulator into this block reproduces the increments exactly, under random iValid/iReady toggling.
